// File: rtl/mole_game_pkg.sv
// ---------------------------------------------------------------------------
// mole_game_pkg
// Shared definitions for the reaction-game controller:
//   state_t             - controller FSM states
//   LFSR_TAPS           - feedback mask for the 16-bit Fibonacci LFSR
//                         (taps 16,14,13,11 -> bits 15,13,12,10)
//   LFSR_DEFAULT_SEED   - non-zero power-up value of the LFSR
//   SCORE_W / SCORE_MAX - hit counter width and saturation value
//   lfsr_step()         - one shift of the LFSR
// ---------------------------------------------------------------------------
package mole_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam int                SCORE_W   = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Shift left, feeding the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return {value[14:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_game_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One button path: 2-flop synchronizer, counting debouncer and a rising-edge
// press pulse.
//   i_clk    system clock
//   i_srst   synchronous active-high reset
//   i_raw    raw asynchronous button level
//   o_press  one-cycle pulse, registered, one cycle after the debounced
//            level rises
// Latency: raw rising edge first sampled at edge t -> accepted level rises at
// t+DEBOUNCE_CYCLES+1 -> o_press high after edge t+DEBOUNCE_CYCLES+2.
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_raw,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Count consecutive cycles the synced input disagrees with the accepted
      // level; any agreeing cycle restarts the count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/mole_game_ctrl.sv
// ---------------------------------------------------------------------------
// mole_game_ctrl
// Player-side controller of the reaction-timer game. Debounces the start and
// hole buttons, lights a pseudo-random target, judges presses and issues the
// start/miss pulses used by the countdown timer.
//   clock       system clock
//   reset       synchronous active-high reset
//   btn_start   raw start button
//   btn         raw hole buttons (N_HOLES)
//   game_over   level from the timer, forces OVER outside IDLE
//   start       one-cycle pulse when a game begins
//   miss        one-cycle pulse per miss (wrong press, multi-press, timeout)
//   hit         one-cycle pulse per correct press
//   target_led  one-hot lit hole, zero when dark
//   score       saturating hit count
//   busy        high while in GAP or SHOW
// All outputs are registered from the next-state logic, so LEDs and pulses
// change on the same edge as the state.
// ---------------------------------------------------------------------------
module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int          N_HOLES         = 8,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          TARGET_CYCLES   = 50000000,
  parameter int          GAP_CYCLES      = 10000000,
  parameter logic [15:0] LFSR_SEED       = LFSR_DEFAULT_SEED
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_start,
  input  logic [N_HOLES-1:0] btn,
  input  logic               game_over,
  output logic               start,
  output logic               miss,
  output logic               hit,
  output logic [N_HOLES-1:0] target_led,
  output logic [SCORE_W-1:0] score,
  output logic               busy
);

  localparam int IDX_W   = $clog2(N_HOLES);
  localparam int CNT_MAX = (TARGET_CYCLES > GAP_CYCLES) ? TARGET_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Bit N_HOLES is the start button, bits below are the holes.
  logic [N_HOLES:0]   w_raw_btn;
  logic [N_HOLES:0]   w_press_all;
  logic [N_HOLES-1:0] w_press;
  logic               w_start_press;

  assign w_raw_btn     = {btn_start, btn};
  assign w_press       = w_press_all[N_HOLES-1:0];
  assign w_start_press = w_press_all[N_HOLES];

  generate
    for (genvar gi = 0; gi <= N_HOLES; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .i_clk  (clock),
        .i_srst (reset),
        .i_raw  (w_raw_btn[gi]),
        .o_press(w_press_all[gi])
      );
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_next;
  logic               r_first;
  logic               w_first_next;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_next;
  logic [15:0]        r_lfsr;
  logic               r_start;
  logic               r_miss;
  logic               r_hit;
  logic               w_start_next;
  logic               w_miss_next;
  logic               w_hit_next;
  logic [N_HOLES-1:0] r_led;
  logic [N_HOLES-1:0] w_led_next;
  logic               r_busy;
  logic               w_busy_next;

  // Candidate target: raw LFSR bits, bumped by one if it repeats the previous
  // target. Power-of-two hole count makes the +1 wrap naturally.
  logic [IDX_W-1:0] w_raw_idx;
  logic [IDX_W-1:0] w_new_idx;

  assign w_raw_idx = r_lfsr[IDX_W-1:0];
  assign w_new_idx = (!r_first && (w_raw_idx == r_idx)) ? w_raw_idx + IDX_W'(1) : w_raw_idx;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_idx_next   = r_idx;
    w_first_next = r_first;
    w_score_next = r_score;
    w_start_next = 1'b0;
    w_miss_next  = 1'b0;
    w_hit_next   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_start_press && !game_over) begin
          w_start_next = 1'b1;
          w_score_next = '0;
          w_first_next = 1'b1;
          w_state_next = ST_GAP;
        end
      end

      ST_GAP: begin
        if (game_over) begin
          w_state_next = ST_OVER;
          w_cnt_next   = '0;
        end else begin
          if (|w_press) begin
            w_miss_next = 1'b1;
          end
          if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
            w_state_next = ST_SHOW;
            w_cnt_next   = '0;
            w_idx_next   = w_new_idx;
            w_first_next = 1'b0;
          end
        end
      end

      ST_SHOW: begin
        if (game_over) begin
          w_state_next = ST_OVER;
          w_cnt_next   = '0;
        end else if (|w_press) begin
          // A press wins over a timeout landing on the same edge.
          if (w_press == r_led) begin
            w_hit_next   = 1'b1;
            w_score_next = (r_score == SCORE_MAX) ? r_score : r_score + SCORE_W'(1);
          end else begin
            w_miss_next = 1'b1;
          end
          w_state_next = ST_GAP;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_W'(TARGET_CYCLES - 1)) begin
          w_miss_next  = 1'b1;
          w_state_next = ST_GAP;
          w_cnt_next   = '0;
        end
      end

      default: begin
        w_cnt_next = '0;
      end
    endcase
  end

  assign w_led_next  = (w_state_next == ST_SHOW) ? (N_HOLES'(1) << w_idx_next) : '0;
  assign w_busy_next = (w_state_next == ST_GAP) || (w_state_next == ST_SHOW);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_first <= 1'b1;
      r_score <= '0;
      r_lfsr  <= LFSR_SEED;
      r_start <= 1'b0;
      r_miss  <= 1'b0;
      r_hit   <= 1'b0;
      r_led   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_first <= w_first_next;
      r_score <= w_score_next;
      r_lfsr  <= lfsr_step(r_lfsr);
      r_start <= w_start_next;
      r_miss  <= w_miss_next;
      r_hit   <= w_hit_next;
      r_led   <= w_led_next;
      r_busy  <= w_busy_next;
    end
  end

  assign start      = r_start;
  assign miss       = r_miss;
  assign hit        = r_hit;
  assign target_led = r_led;
  assign score      = r_score;
  assign busy       = r_busy;

endmodule
